module_operand_entry: RTL

Front-end operand capture for the hex adder FSM. Collects hex key presses (already debounced, one-cycle strobes) into two 12-bit operands, num1 then num2. It then presents both on num1_hex and num2_hex with a valid/ack handshake. It is the producer side of the num1_hex/num2_hex interface that the adder FSM consumes.

---
 rtl/module_operand_entry_if.sv | 26 ++
 rtl/module_operand_entry.sv | 119 +++++++++++
 2 files changed

// File: rtl/module_operand_entry_if.sv
// Operand-entry bus: keypad strobes in, captured operands and handshake out.
// master = the operand-entry block, slave = keypad driver / adder consumer.
interface module_operand_entry_if #(
  parameter int DIGITS = 3
);
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_enter;
  logic                key_clear;
  logic                operands_ack;
  logic [4*DIGITS-1:0] num1_hex;
  logic [4*DIGITS-1:0] num2_hex;
  logic                operands_valid;
  logic [1:0]          digit_count;
  logic [1:0]          state;

  modport master (
    input  key_code, key_valid, key_enter, key_clear, operands_ack,
    output num1_hex, num2_hex, operands_valid, digit_count, state
  );

  modport slave (
    output key_code, key_valid, key_enter, key_clear, operands_ack,
    input  num1_hex, num2_hex, operands_valid, digit_count, state
  );
endinterface

// File: rtl/module_operand_entry.sv
// Collects hex key strobes into two operands and offers them to the adder
// FSM with a valid/ack handshake. All outputs come straight from flops.
module module_operand_entry #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  module_operand_entry_if.master bus
);

  localparam int         OP_W    = 4 * DIGITS;
  localparam logic [1:0] MAX_CNT = 2'(DIGITS);

  typedef enum logic [1:0] {
    S_NUM1  = 2'b00,
    S_NUM2  = 2'b01,
    S_VALID = 2'b10,
    S_BAD   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   num1_q, num1_d;
  logic [OP_W-1:0]   num2_q, num2_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [OP_W-1:0]   op_cur, op_nxt;

  // First digit of an operand discards whatever was there before.
  function automatic logic [OP_W-1:0] load_digit(input logic [3:0] code);
    return OP_W'(code);
  endfunction

  // Truncating cast drops the top nibble; only reached while below DIGITS.
  function automatic logic [OP_W-1:0] shift_digit(input logic [OP_W-1:0] op,
                                                  input logic [3:0]      code);
    return OP_W'({op, code});
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_NUM1;
      num1_q  <= '0;
      num2_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    op_cur  = (state_q == S_NUM2) ? num2_q : num1_q;
    op_nxt  = op_cur;

    unique case (state_q)
      S_NUM1, S_NUM2: begin
        valid_d = 1'b0;
        // clear beats enter beats digit; losers in the same cycle are dropped
        if (bus.key_clear) begin
          op_nxt = '0;
          cnt_d  = 2'd0;
        end else if (bus.key_enter) begin
          cnt_d = 2'd0;
          if (state_q == S_NUM1) begin
            state_d = S_NUM2;
          end else begin
            state_d = S_VALID;
            valid_d = 1'b1;
          end
        end else if (bus.key_valid) begin
          if (cnt_q == 2'd0) begin
            op_nxt = load_digit(bus.key_code);
            cnt_d  = 2'd1;
          end else if (cnt_q < MAX_CNT) begin
            op_nxt = shift_digit(op_cur, bus.key_code);
            cnt_d  = 2'(cnt_q + 2'd1);
          end
        end

        if (state_q == S_NUM1) begin
          num1_d = op_nxt;
        end else begin
          num2_d = op_nxt;
        end
      end

      S_VALID: begin
        valid_d = 1'b1;
        cnt_d   = 2'd0;
        if (bus.operands_ack) begin
          state_d = S_NUM1;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_NUM1;
        cnt_d   = 2'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.num1_hex       = num1_q;
  assign bus.num2_hex       = num2_q;
  assign bus.operands_valid = valid_q;
  assign bus.digit_count    = cnt_q;
  assign bus.state          = state_q;

endmodule
